// File: rtl/pipe_issue_sched.sv
// ---------------------------------------------------------------------------
// pipe_issue_sched
//
// Two-requester instruction issue scheduler. Each requester owns a FIFO of
// DEPTH entries. Every cycle at most one queue head is popped (round-robin
// when both queues hold work) and presented one cycle later on inst_out, with
// issue_valid/issue_src qualifying it. Cycles with no issue carry a NOP
// (8'h00). A flush empties both queues and suppresses issue and pushes for
// that cycle.
//
// Optional feature: define SCHED_HAZARD_STALL_EN to track the destination
// register of the previously issued instruction and insert a NOP bubble when
// the selected head reads it (RAW stall). Without the macro the pipeline is
// assumed to forward, so no bubbles are inserted and no tracker exists.
//
// Parameters
//   DEPTH  per-requester queue depth (power of 2, >= 2)
//   CNT_W  width of the per-requester issue counters
//
// Ports
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active low
//   req0_valid/req1_valid    requester offers an instruction
//   req0_inst/req1_inst      {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}
//   req0_ready/req1_ready    queue not full and no flush this cycle
//   flush                    discard all queued instructions
//   inst_out                 registered instruction to the pipeline
//   issue_valid              inst_out carries a requester instruction
//   issue_src                requester index of inst_out (when issue_valid)
//   issue_cnt0/issue_cnt1    wrapping issue counters per requester
//   busy                     FSM not IDLE or any queue non-empty
// ---------------------------------------------------------------------------
module pipe_issue_sched #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_inst,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_inst,
  output logic             req1_ready,
  input  logic             flush,
  output logic [7:0]       inst_out,
  output logic             issue_valid,
  output logic             issue_src,
  output logic [CNT_W-1:0] issue_cnt0,
  output logic [CNT_W-1:0] issue_cnt1,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Queue storage and bookkeeping, indexed by requester.
  logic [7:0]    mem       [2][DEPTH];
  logic [AW-1:0] rd_ptr    [2];
  logic [AW-1:0] wr_ptr    [2];
  logic [AW:0]   count     [2];
  logic [AW:0]   count_nxt [2];
  logic [7:0]    push_inst [2];

  logic [1:0] not_empty;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic       sel;       // requester whose head is considered this cycle
  logic       stall;     // hazard bubble instead of issuing the head
  logic       do_pop;
  logic       rr_last;   // requester granted most recently
  logic [7:0] head;

`ifdef SCHED_HAZARD_STALL_EN
  logic [1:0] haz_rd;    // rd of the instruction issued last cycle
  logic       haz_we;    // that instruction writes rd (op != 00)
`endif

  // -------------------------------------------------------------------------
  // Selection, handshakes and next occupancy
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a value on every path (defaults
  // first), so the block stays purely combinational and infers no latches.
  always_comb begin
    push_inst[0] = req0_inst;
    push_inst[1] = req1_inst;

    for (int i = 0; i < 2; i++) begin
      not_empty[i] = (count[i] != '0);
      full[i]      = (count[i] == (AW+1)'(DEPTH));
    end

    // Ready looks only at current occupancy: a full queue refuses a push
    // even in a cycle where it is also popped.
    req0_ready = !full[0] && !flush;
    req1_ready = !full[1] && !flush;
    push       = {req1_valid && req1_ready, req0_valid && req0_ready};

    // Only one queue with work wins outright; with both, the one not
    // granted last time wins.
    if (&not_empty) sel = ~rr_last;
    else            sel = not_empty[1];

    head = mem[sel][rd_ptr[sel]];

`ifdef SCHED_HAZARD_STALL_EN
    stall = haz_we && ((head[5:4] == haz_rd) || (head[3:2] == haz_rd));
`else
    stall = 1'b0;
`endif

    // Flush outranks any pop; an empty queue pair has nothing to pop.
    do_pop = (|not_empty) && !flush && !stall;
    pop    = {do_pop && sel, do_pop && !sel};

    for (int i = 0; i < 2; i++) begin
      count_nxt[i] = count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Queue pointers and occupancy
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count_nxt[i];
      end
    end
  end

  // NOTE: the entry storage has no reset; occupancy counts alone decide
  // which entries are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= push_inst[i];
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (|not_empty) state_nxt = ISSUE;
        ISSUE:   if ((count_nxt[0] == '0) && (count_nxt[1] == '0)) state_nxt = IDLE;
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (|not_empty);

  // -------------------------------------------------------------------------
  // Issue register, round-robin pointer and counters
  // -------------------------------------------------------------------------
  // A popped head lives only in these flops until the next edge, so reset
  // discards anything popped but not yet presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_out    <= 8'h00;
      issue_valid <= 1'b0;
      issue_src   <= 1'b0;
      rr_last     <= 1'b1;
      issue_cnt0  <= '0;
      issue_cnt1  <= '0;
    end else begin
      inst_out    <= do_pop ? head : 8'h00;
      issue_valid <= do_pop;
      issue_src   <= do_pop && sel;
      if (do_pop) rr_last    <= sel;
      if (pop[0]) issue_cnt0 <= issue_cnt0 + CNT_W'(1);
      if (pop[1]) issue_cnt1 <= issue_cnt1 + CNT_W'(1);
    end
  end

`ifdef SCHED_HAZARD_STALL_EN
  // Any cycle without an issue (bubble, idle, flush) sends a NOP down the
  // pipe, which writes nothing, so the tracker clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      haz_rd <= 2'b00;
      haz_we <= 1'b0;
    end else begin
      haz_rd <= do_pop ? head[1:0] : 2'b00;
      haz_we <= do_pop && (head[7:6] != 2'b00);
    end
  end
`endif

endmodule

// File: doc/pipe_issue_sched.md
PIPE_ISSUE_SCHED -- requirements
Module: pipe_issue_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-requester queue depth (power of 2, >= 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the per-requester issue counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, requester offers an instruction.
REQ-006 SHALL have ports req0_inst / req1_inst, input, 8, instruction {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1, queue can accept; asserted iff queue not full and flush low.
REQ-008 SHALL have port flush, input, 1, discard all queued instructions.
REQ-009 SHALL have port inst_out, output, 8, registered instruction driven to the pipeline's inst input.
REQ-010 SHALL have port issue_valid, output, 1, registered; inst_out carries a requester instruction this cycle.
REQ-011 SHALL have port issue_src, output, 1, registered; requester index of inst_out, meaningful only when issue_valid=1.
REQ-012 SHALL have ports issue_cnt0 / issue_cnt1, output, CNT_W, instructions issued per requester.
REQ-013 SHALL have port busy, output, 1, state != IDLE or any queue non-empty.

Function
REQ-014 SHALL push reqN_inst into FIFO queue N when reqN_valid && reqN_ready; ready depends only on current-cycle occupancy (no push into a full queue even when it pops that cycle).
REQ-015 SHALL select at most one queue head per cycle: only one non-empty -> that one; both non-empty -> requester not granted last (round-robin pointer, reset value points to requester 1 so requester 0 wins first).
REQ-016 SHALL pop the selected head and present it on inst_out with issue_valid=1 and issue_src set on the following cycle (latency 1 from pop; minimum latency push -> inst_out = 2 cycles).
REQ-017 SHALL drive inst_out=8'h00 (NOP) and issue_valid=0 in every cycle with no issue.
REQ-018 SHALL issue requester instructions with op=00 unchanged, counting them as issued.
REQ-019 SHALL increment issue_cntN by 1 per issue from requester N, wrapping from 2^CNT_W-1 to 0.
REQ-020 SHALL implement FSM IDLE/ISSUE/FLUSH: IDLE -> ISSUE when any queue non-empty; ISSUE -> IDLE when both queues empty after a pop; any state -> FLUSH when flush=1; FLUSH -> IDLE after exactly one cycle.
REQ-021 SHALL, on flush=1, empty both queues, issue nothing that cycle, drop any same-cycle push (ready low), leave counters and round-robin pointer unchanged; inst_out=NOP next cycle.
REQ-022 SHALL give flush priority over push and pop in the same cycle.

Reset
REQ-023 SHALL, on rst low, asynchronously clear: queues empty, FSM IDLE, pointer -> requester 1, inst_out=8'h00, issue_valid=0, issue_src=0, counters 0, hazard tracker cleared.
REQ-024 SHALL discard any instruction popped but not yet presented when reset asserts mid-operation.

Configuration
REQ-025 SHALL, with macro SCHED_HAZARD_STALL_EN defined, track rd and write-enable (op!=00) of the previously issued instruction and, if the selected head's rs1 or rs2 equals that rd, issue a NOP bubble instead, hold the head, not advance the pointer.
REQ-026 SHALL, without SCHED_HAZARD_STALL_EN, never insert bubbles (pipeline forwards), and contain no hazard tracker logic.

Verification
REQ-027 SHALL test: after reset, req0 pushes 8'h41 -> inst_out=8'h41, issue_valid=1, issue_src=0 two cycles after push; issue_cnt0=1.
REQ-028 SHALL test: both queues hold 2 entries (A0,A1 / B0,B1) -> issue order A0,B0,A1,B1 on consecutive cycles, then NOP, busy falls.
REQ-029 SHALL test: fill queue 0 with DEPTH=2 -> req0_ready=0 until a pop; third push held, accepted only after ready rises.
REQ-030 SHALL test: flush with 2 entries queued and req1_valid=1 -> no issue, queues empty, push dropped, counters unchanged, FSM IDLE after one cycle.
REQ-031 SHALL test: with SCHED_HAZARD_STALL_EN, issue 8'h43 (ADD r3) then 8'h7C (reads r3) -> one NOP bubble between; without the macro -> back-to-back.
REQ-032 SHALL test: issue_cnt0 preloaded to 255 via 255 issues, one more issue -> 0; rst low mid-stream -> all outputs at reset values immediately.
